// File: rtl/vtx1_imem_fetch_responder.sv
// ---------------------------------------------------------------------------
// vtx1_imem_fetch_responder
//
// Assembles a VLIW instruction bundle of BEATS memory words for the CPU
// fetch port. A request captures a base word address. The block then reads
// BEATS consecutive words, with the address wrapping modulo 2^WORD_W. The
// response is one registered cycle of imem_ready with the bundle on
// imem_data. Each beat has a wait budget of TIMEOUT cycles. If a beat runs
// out of budget, the fetch is abandoned and answered with imem_data = 0
// and a fetch_error pulse.
//
// Optional feature (macro VTX1_IMEM_LASTHIT_EN):
//   A one-entry last-bundle buffer holds the address and data of the last
//   bundle that completed successfully. A matching request in IDLE is
//   answered without any memory reads. imem_flush (or rst) invalidates the
//   entry. A flush that arrives together with a hit forces a full fetch.
//   When the macro is undefined, imem_flush is ignored.
//
// Ports:
//   clk          in   sole clock, rising edge
//   rst          in   asynchronous active-high reset
//   imem_req     in   fetch request, held with imem_addr until imem_ready
//   imem_addr    in   [WORD_W]  bundle base word address
//   imem_data    out  [WORD_W*BEATS] bundle, beat k at [k*WORD_W +: WORD_W]
//   imem_ready   out  one-cycle response pulse
//   imem_flush   in   invalidate last-bundle buffer
//   mem_rd       out  external read strobe
//   mem_addr     out  [WORD_W]  external word address
//   mem_rdata    in   [WORD_W]  external read data
//   mem_valid    in   read data valid (only looked at while mem_rd = 1)
//   busy         out  state is not IDLE
//   fetch_error  out  one-cycle pulse with imem_ready on a beat timeout
// ---------------------------------------------------------------------------
module vtx1_imem_fetch_responder #(
    parameter int WORD_W  = 32,
    parameter int BEATS   = 3,
    parameter int TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      imem_req,
    input  logic [WORD_W-1:0]         imem_addr,
    output logic [WORD_W*BEATS-1:0]   imem_data,
    output logic                      imem_ready,
    input  logic                      imem_flush,
    output logic                      mem_rd,
    output logic [WORD_W-1:0]         mem_addr,
    input  logic [WORD_W-1:0]         mem_rdata,
    input  logic                      mem_valid,
    output logic                      busy,
    output logic                      fetch_error
);

    localparam int VLIW_W = WORD_W * BEATS;
    localparam int K_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   base_q,  base_d;   // captured bundle address
    logic [K_W-1:0]      k_q,     k_d;      // current beat
    logic [WAIT_W-1:0]   wait_q,  wait_d;   // stall cycles on current beat
    logic                err_q,   err_d;    // bundle timed out
    logic [VLIW_W-1:0]   slots_q, slots_d;  // bundle being assembled
    logic [VLIW_W-1:0]   data_q,  data_d;   // last delivered bundle
    logic                ready_q, ready_d;
    logic                ferr_q,  ferr_d;

    // Last-bundle lookup result, always visible to the FSM.
    logic                hit;
    logic [VLIW_W-1:0]   hit_data;

`ifdef VTX1_IMEM_LASTHIT_EN
    logic                lh_valid_q;
    logic [WORD_W-1:0]   lh_addr_q;
    logic [VLIW_W-1:0]   lh_data_q;

    // A flush in the request cycle masks the hit, so a full fetch starts.
    assign hit      = lh_valid_q && !imem_flush && (lh_addr_q == imem_addr);
    assign hit_data = lh_data_q;

    // The entry is refreshed only by a response without error.
    // A timed-out bundle therefore never becomes a hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lh_valid_q <= 1'b0;
            lh_addr_q  <= '0;
            lh_data_q  <= '0;
        end else if (imem_flush) begin
            lh_valid_q <= 1'b0;
        end else if (state_q == RESP && !err_q) begin
            lh_valid_q <= 1'b1;
            lh_addr_q  <= base_q;
            lh_data_q  <= slots_q;
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_data = '0;

    logic unused_flush;
    assign unused_flush = imem_flush;
`endif

    // Next-state and datapath logic.
    // NOTE: every signal assigned here gets a default first. Without a
    // default, a path that does not assign the signal infers a latch.
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        k_d      = k_q;
        wait_d   = wait_q;
        err_d    = err_q;
        slots_d  = slots_q;
        data_d   = data_q;
        ready_d  = 1'b0;
        ferr_d   = 1'b0;
        mem_rd   = 1'b0;
        mem_addr = '0;

        case (state_q)
            IDLE: begin
                if (imem_req) begin
                    base_d = imem_addr;
                    k_d    = '0;
                    wait_d = '0;
                    err_d  = 1'b0;
                    if (hit) begin
                        slots_d = hit_data;
                        state_d = RESP;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end

            FETCH: begin
                mem_rd   = 1'b1;
                mem_addr = base_q + WORD_W'(k_q);
                if (mem_valid) begin
                    for (int b = 0; b < BEATS; b++) begin
                        if (k_q == K_W'(b)) begin
                            slots_d[b*WORD_W +: WORD_W] = mem_rdata;
                        end
                    end
                    wait_d = '0;
                    if (k_q == K_W'(BEATS - 1)) begin
                        state_d = RESP;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th stalled cycle on this beat.
                    err_d   = 1'b1;
                    wait_d  = '0;
                    state_d = RESP;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            RESP: begin
                // Outputs are registered, so the pulse appears in the
                // following cycle, with the FSM already back in IDLE.
                ready_d = 1'b1;
                ferr_d  = err_q;
                data_d  = err_q ? '0 : slots_q;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only. All
    // registers then update together from values taken before the edge.
    // NOTE: the bundle slots are reset along with the control state. The
    // array is small, and the reset keeps X out of imem_data and out of
    // the last-bundle buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            k_q     <= '0;
            wait_q  <= '0;
            err_q   <= 1'b0;
            slots_q <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            k_q     <= k_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            slots_q <= slots_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            ferr_q  <= ferr_d;
        end
    end

    assign imem_data   = data_q;
    assign imem_ready  = ready_q;
    assign fetch_error = ferr_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_vtx1_imem_fetch_responder.sv
module tb_vtx1_imem_fetch_responder;

    localparam int WORD_W = 32;
    localparam int BEATS  = 3;
    localparam int VLIW_W = WORD_W * BEATS;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              imem_req = 1'b0;
    logic [31:0]       imem_addr = '0;
    logic [95:0]       imem_data;
    logic              imem_ready;
    logic              imem_flush = 1'b0;
    logic              mem_rd;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_rdata;
    logic              mem_valid;
    logic              busy;
    logic              fetch_error;

    vtx1_imem_fetch_responder #(
        .WORD_W  (WORD_W),
        .BEATS   (BEATS),
        .TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .imem_ready  (imem_ready),
        .imem_flush  (imem_flush),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mem_valid   (mem_valid),
        .busy        (busy),
        .fetch_error (fetch_error)
    );

    always #5 clk = ~clk;

    // Memory model: data = address ^ A5A50000. The word at stall_addr is
    // withheld for stall_n cycles. dead withholds every word.
    logic [31:0] stall_addr = 32'hDEAD_BEEF;
    int          stall_n    = 0;
    bit          dead       = 1'b0;
    int          wait_ctr   = 0;

    assign mem_rdata = mem_addr ^ 32'hA5A5_0000;
    assign mem_valid = mem_rd && !dead && ((mem_addr != stall_addr) || (wait_ctr >= stall_n));

    always @(posedge clk) begin
        if (!mem_rd || mem_valid) wait_ctr <= 0;
        else                      wait_ctr <= wait_ctr + 1;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Results of the last do_fetch.
    int            r_lat;
    int            r_rd;
    logic [95:0]   r_data;
    logic          r_err;
    logic          r_busy0;
    logic          r_busy_resp;
    logic [31:0]   addr_log[$];

    // Issue a request and follow it until imem_ready.
    // r_lat counts edges after the sampling edge until imem_ready is seen.
    // hold keeps imem_req high until the response.
    // linger also keeps it high through the ready cycle.
    task automatic do_fetch(input logic [31:0] a, input bit hold, input bit linger, input bit flush);
        bit done;
        @(negedge clk);
        imem_req   = 1'b1;
        imem_addr  = a;
        imem_flush = flush;
        @(posedge clk);
        wait_resp(a, hold, linger);
    endtask

    // Call this right after the edge that samples the request.
    task automatic wait_resp(input logic [31:0] a, input bit hold, input bit linger);
        bit done;
        done  = 1'b0;
        r_lat = 0;
        r_rd  = 0;
        addr_log.delete();
        #1;
        imem_flush = 1'b0;
        if (!hold) imem_req = 1'b0;
        r_busy0 = busy;
        while (!done && r_lat <= 64) begin
            if (mem_rd) begin
                r_rd++;
                addr_log.push_back(mem_addr);
            end
            if (imem_ready) begin
                done        = 1'b1;
                r_data      = imem_data;
                r_err       = fetch_error;
                r_busy_resp = busy;
                if (!linger) imem_req = 1'b0;
            end else begin
                @(posedge clk);
                #1;
                r_lat++;
            end
        end
        if (!done) begin
            check("resp_timeout", 96'(a), 96'hFFFF_FFFF_FFFF);
        end else if (!linger) begin
            @(posedge clk);
            #1;
            check("ready_pulse_width", 96'(imem_ready), 96'd0);
        end
    endtask

    task automatic check_fetch(input string tag, input int exp_lat, input int exp_rd,
                               input logic [95:0] exp_data, input logic exp_err);
        check({tag, "_latency"}, 96'(r_lat), 96'(exp_lat));
        check({tag, "_rd_cycles"}, 96'(r_rd), 96'(exp_rd));
        check({tag, "_data"}, r_data, exp_data);
        check({tag, "_error"}, 96'(r_err), 96'(exp_err));
        check({tag, "_busy_first"}, 96'(r_busy0), 96'd1);
        check({tag, "_busy_at_ready"}, 96'(r_busy_resp), 96'd0);
    endtask

    localparam logic [95:0] B100 = 96'hA5A50102_A5A50101_A5A50100;
    localparam logic [95:0] B200 = 96'hA5A50202_A5A50201_A5A50200;
    localparam logic [95:0] B300 = 96'hA5A50302_A5A50301_A5A50300;
    localparam logic [95:0] B500 = 96'hA5A50502_A5A50501_A5A50500;
    localparam logic [95:0] BFFF = 96'hA5A50001_A5A50000_5A5AFFFF;
    localparam logic [95:0] B600 = 96'hA5A50602_A5A50601_A5A50600;
    localparam logic [95:0] B700 = 96'hA5A50702_A5A50701_A5A50700;

`ifdef VTX1_IMEM_LASTHIT_EN
    localparam int HIT_LAT = 1;
    localparam int HIT_RD  = 0;
`else
    localparam int HIT_LAT = 4;
    localparam int HIT_RD  = 3;
`endif

    initial begin
        int cnt;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 96'(imem_ready), 96'd0);
        check("rst_mem_rd", 96'(mem_rd), 96'd0);
        check("rst_busy", 96'(busy), 96'd0);
        check("rst_error", 96'(fetch_error), 96'd0);
        check("rst_data", imem_data, 96'd0);
        check("rst_mem_addr", 96'(mem_addr), 96'd0);
        rst = 1'b0;

        // Zero-wait fetch at 0x100, request held until ready
        do_fetch(32'h100, 1'b1, 1'b0, 1'b0);
        check_fetch("zw", 4, 3, B100, 1'b0);
        check("zw_addr0", 96'(addr_log[0]), 96'h100);
        check("zw_addr1", 96'(addr_log[1]), 96'h101);
        check("zw_addr2", 96'(addr_log[2]), 96'h102);

        // Beat 1 stalled 5 cycles; request dropped right after sampling
        stall_addr = 32'h201;
        stall_n    = 5;
        do_fetch(32'h200, 1'b0, 1'b0, 1'b0);
        check_fetch("stall", 9, 8, B200, 1'b0);
        cnt = 0;
        foreach (addr_log[i]) if (addr_log[i] == 32'h201) cnt++;
        check("stall_beat1_held", 96'(cnt), 96'd6);
        check("stall_last_addr", 96'(addr_log[addr_log.size()-1]), 96'h202);
        stall_addr = 32'hDEAD_BEEF;
        stall_n    = 0;

        // Beat 0 never answered -> timeout
        dead = 1'b1;
        do_fetch(32'h300, 1'b1, 1'b0, 1'b0);
        check_fetch("tmo", 17, 16, 96'd0, 1'b1);
        check("tmo_addr_beat0", 96'(addr_log[15]), 96'h300);
        dead = 1'b0;
        // The timed-out bundle is not buffered: a full fetch follows
        do_fetch(32'h300, 1'b1, 1'b0, 1'b0);
        check_fetch("after_tmo", 4, 3, B300, 1'b0);

        // Reset pulsed during beat 1
        stall_addr = 32'h501;
        stall_n    = 10;
        @(negedge clk);
        imem_req  = 1'b1;
        imem_addr = 32'h500;
        @(posedge clk);
        #1;
        imem_req = 1'b0;
        @(posedge clk);
        #1;
        check("rstmid_beat1_addr", 96'(mem_addr), 96'h501);
        rst = 1'b1;
        #1;
        check("rstmid_mem_rd", 96'(mem_rd), 96'd0);
        check("rstmid_mem_addr", 96'(mem_addr), 96'd0);
        check("rstmid_busy", 96'(busy), 96'd0);
        check("rstmid_data", imem_data, 96'd0);
        check("rstmid_error", 96'(fetch_error), 96'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("rstmid_no_ready", 96'(imem_ready), 96'd0);
        end
        rst     = 1'b0;
        stall_n = 0;
        do_fetch(32'h500, 1'b1, 1'b0, 1'b0);
        check_fetch("restart", 4, 3, B500, 1'b0);
        check("restart_addr0", 96'(addr_log[0]), 96'h500);
        stall_addr = 32'hDEAD_BEEF;

        // Address wrap-around
        do_fetch(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        check_fetch("wrap", 4, 3, BFFF, 1'b0);
        check("wrap_addr0", 96'(addr_log[0]), 96'hFFFF_FFFF);
        check("wrap_addr1", 96'(addr_log[1]), 96'h0);
        check("wrap_addr2", 96'(addr_log[2]), 96'h1);

        // Request still high in the ready cycle counts as a new request
        do_fetch(32'h600, 1'b1, 1'b1, 1'b0);
        check_fetch("linger1", 4, 3, B600, 1'b0);
        @(posedge clk);
        wait_resp(32'h600, 1'b0, 1'b0);
        check_fetch("linger2", HIT_LAT, HIT_RD, B600, 1'b0);

        // Repeat, flush-with-hit, repeat
        do_fetch(32'h700, 1'b1, 1'b0, 1'b0);
        check_fetch("rep1", 4, 3, B700, 1'b0);
        do_fetch(32'h700, 1'b1, 1'b0, 1'b0);
        check_fetch("rep2", HIT_LAT, HIT_RD, B700, 1'b0);
        do_fetch(32'h700, 1'b1, 1'b0, 1'b1);
        check_fetch("flush", 4, 3, B700, 1'b0);
        do_fetch(32'h700, 1'b1, 1'b0, 1'b0);
        check_fetch("rep3", HIT_LAT, HIT_RD, B700, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vtx1_imem_fetch_responder.md
VTX1_IMEM_FETCH_RESPONDER -- requirements
Module: vtx1_imem_fetch_responder

Interface
REQ-001 Parameter WORD_W, default 32: width of imem_addr, mem_addr and mem_rdata.
REQ-002 Parameter BEATS, default 3: memory words per VLIW bundle; VLIW_W = WORD_W*BEATS (96).
REQ-003 Parameter TIMEOUT, default 16: maximum wait cycles per beat for mem_valid.
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 imem_req  in  1  CPU fetch request; held with imem_addr stable until imem_ready.
REQ-008 imem_addr  in  WORD_W  bundle base word address.
REQ-009 imem_data  out  VLIW_W  fetched bundle; beat k occupies bits [k*WORD_W +: WORD_W].
REQ-010 imem_ready  out  1  one-cycle response pulse; imem_data is valid in that cycle.
REQ-011 imem_flush  in  1  invalidates the last-bundle buffer.
REQ-012 mem_rd  out  1  external word read strobe.
REQ-013 mem_addr  out  WORD_W  external word address.
REQ-014 mem_rdata  in  WORD_W  external read data; sampled when mem_valid = 1.
REQ-015 mem_valid  in  1  read data valid; sampled only while mem_rd = 1.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 fetch_error  out  1  one-cycle pulse on a beat timeout, coincident with imem_ready.

Function
REQ-018 States: IDLE, FETCH, RESP.
REQ-019 IDLE with imem_req = 1: capture imem_addr, clear beat counter k, go to FETCH.
REQ-020 FETCH: mem_rd = 1, mem_addr = captured_addr + k, with wrap-around modulo 2^WORD_W.
REQ-021 FETCH with mem_valid = 1: store mem_rdata into slot k, reset the wait counter, increment k; when k = BEATS-1, go to RESP.
REQ-022 FETCH wait counter counts cycles with mem_rd = 1 and mem_valid = 0; on reaching TIMEOUT, zero imem_data, set the error flag and go to RESP.
REQ-023 RESP: imem_ready = 1 for exactly one cycle, fetch_error = error flag, then go to IDLE.
REQ-024 Zero-wait memory latency: request sampled at edge N, imem_ready high in the cycle after edge N+BEATS+1.
REQ-025 imem_data holds its value between responses; it updates only when a bundle completes.
REQ-026 imem_req deasserted mid-fetch: the fetch completes and the imem_ready pulse is still issued; there is no abort.
REQ-027 imem_req high in the IDLE cycle after RESP: treated as a new request.
REQ-028 mem_rd = 0 in IDLE and RESP.

Reset
REQ-029 rst asserted: state = IDLE; imem_ready, mem_rd, busy and fetch_error = 0; imem_data = 0; mem_addr = 0; counters = 0; buffer invalid. These values apply immediately, including mid-fetch.
REQ-030 First request is accepted at the first rising edge after rst deasserts.

Configuration
REQ-031 Macro VTX1_IMEM_LASTHIT_EN.
REQ-032 Defined: a one-entry buffer holds the address of the last successfully completed bundle plus a valid bit. An IDLE request whose address matches a valid entry goes directly to RESP, with imem_ready in the next cycle and no mem_rd.
REQ-033 Defined: a timed-out bundle is never buffered. imem_flush = 1 or rst clears the valid bit. If imem_flush and a hit occur in the same cycle, the flush wins and a full fetch starts.
REQ-034 Undefined: no buffer logic; imem_flush is ignored; every request performs BEATS reads.

Verification
REQ-035 Zero-wait memory returning words A0, A1, A2 at address 0x100, single request -> mem_addr 0x100/0x101/0x102; imem_data = {A2,A1,A0}; imem_ready one cycle, 4 cycles after request sample.
REQ-036 mem_valid delayed 5 cycles on beat 1 -> mem_rd held and mem_addr = 0x101 throughout; correct bundle; fetch_error = 0.
REQ-037 mem_valid never asserted on beat 0 -> after 16 cycles, imem_ready = 1, fetch_error = 1, imem_data = 0; next request fetches normally.
REQ-038 rst pulsed during beat 1 -> all outputs 0 immediately; no imem_ready; next request restarts at beat 0.
REQ-039 With LASTHIT: repeat request to 0x100 -> imem_ready 1 cycle after sample, no mem_rd. After imem_flush -> full 3-beat fetch. Without LASTHIT -> both requests fetch.
REQ-040 imem_addr = 0xFFFFFFFF -> mem_addr sequence 0xFFFFFFFF, 0x00000000, 0x00000001.
